// File: rtl/accel_read_arbiter.sv
// accel_read_arbiter
//   Shares the single accelerator read port between NUM_SOURCES FIFO adapters.
//   One source at a time holds the grant for a burst of up to BURST_LEN words.
//   Its head word and can-read flag are forwarded, and the accelerator's pop is
//   routed back as that source's pop strobe. Grants are always separated by one
//   IDLE cycle.
//
// Build option:
//   ARB_FIXED_PRIORITY_EN - when defined, every arbitration scans from source 0
//                           (source 0 highest priority). rr_ptr stays at 0.
//                           When undefined, arbitration is round-robin.
//
// Ports:
//   clk                clock, all state updates on posedge
//   rst                asynchronous active-high reset
//   src_can_read       per-source FIFO non-empty flags (bit i = source i)
//   src_read_data      per-source head words, source i at [16*i+15:16*i]
//   src_read_enable    per-source pop strobe, one-hot or zero
//   accel_can_read     granted source has a word available
//   accel_read_data    head word of the granted source (0 while idle)
//   accel_read_enable  accelerator pops the current word
//   accel_read_source  index of the granted source
//   busy               high while a grant is held
module accel_read_arbiter #(
  parameter int NUM_SOURCES = 2,
  parameter int SRC_WIDTH   = 1,
  parameter int BURST_LEN   = 16,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SOURCES-1:0]    src_can_read,
  input  logic [16*NUM_SOURCES-1:0] src_read_data,
  output logic [NUM_SOURCES-1:0]    src_read_enable,
  output logic                      accel_can_read,
  output logic [15:0]               accel_read_data,
  input  logic                      accel_read_enable,
  output logic [SRC_WIDTH-1:0]      accel_read_source,
  output logic                      busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [SRC_WIDTH-1:0] grant;
  logic [SRC_WIDTH-1:0] grant_next;
  logic [SRC_WIDTH-1:0] rr_ptr;
  logic [SRC_WIDTH-1:0] rr_ptr_next;
  logic [SRC_WIDTH-1:0] pick;
  logic [SRC_WIDTH-1:0] scan_idx;
  logic [CNT_WIDTH-1:0] burst_cnt;
  logic [CNT_WIDTH-1:0] burst_cnt_next;
  logic                 found;
  logic                 head_valid;
  logic                 transfer;
  logic                 burst_last;

  assign head_valid = src_can_read[grant];
  assign transfer   = (state == GRANT) && accel_read_enable && head_valid;
  assign burst_last = (burst_cnt == CNT_WIDTH'(BURST_LEN - 1));

  // First requesting source at or after rr_ptr, wrapping modulo NUM_SOURCES.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      scan_idx = SRC_WIDTH'((int'(rr_ptr) + int'(i)) % NUM_SOURCES);
      if (!found && src_can_read[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  always_comb begin
    state_next     = state;
    grant_next     = grant;
    rr_ptr_next    = rr_ptr;
    burst_cnt_next = burst_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          grant_next     = pick;
          burst_cnt_next = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        // Release when the source runs dry or the last word of a burst is popped.
        if (!head_valid || (transfer && burst_last)) begin
          state_next     = IDLE;
          burst_cnt_next = '0;
`ifdef ARB_FIXED_PRIORITY_EN
          rr_ptr_next    = '0;
`else
          rr_ptr_next    = (grant == SRC_WIDTH'(NUM_SOURCES - 1)) ? '0 : grant + 1'b1;
`endif
        end else if (transfer) begin
          burst_cnt_next = burst_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      rr_ptr    <= rr_ptr_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  // Forwarding path; everything is forced to zero outside GRANT so that an
  // asynchronous reset cuts the pop strobe in the same cycle.
  always_comb begin
    accel_can_read  = 1'b0;
    accel_read_data = '0;
    src_read_enable = '0;
    if (state == GRANT) begin
      accel_can_read = head_valid;
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        if (grant == SRC_WIDTH'(i)) begin
          accel_read_data = src_read_data[16*i +: 16];
        end
      end
      src_read_enable[grant] = transfer;
    end
  end

  assign accel_read_source = grant;
  assign busy              = (state == GRANT);

endmodule
